// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and constants for the fetch sequencer
package fetch_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t S_IDLE  = 2'd0;
  localparam fetch_state_t S_FETCH = 2'd1;
  localparam fetch_state_t S_WAIT  = 2'd2;
  localparam fetch_state_t S_HOLD  = 2'd3;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int          PC_INC           = 4;

endpackage

// File: rtl/fetch_pc_sel.sv
// rtl/fetch_pc_sel.sv - next-pc mux: redirect beats advance, hold freezes the pc
module fetch_pc_sel
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] target,
  input  logic              advance,
  input  logic              hold,
  output logic [ADDR_W-1:0] next_pc,
  output logic              misalign
);

  always_comb begin
    next_pc = pc;
    if (redirect) begin
      next_pc = {target[ADDR_W-1:2], 2'b00};
    end else if (advance && !hold) begin
      next_pc = pc + ADDR_W'(PC_INC);
    end
  end

  assign misalign = redirect & (|target[1:0]);

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - single-outstanding instruction fetch sequencer with redirect and stale-kill
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_instr,
  input  logic              if_ready,
  output logic              misalign
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic              kill;

  logic [ADDR_W-1:0] pc_next;
  logic              misalign_next;
  logic              advance;
  logic              hold;

  // Only a clean, unkilled response with no same-cycle redirect moves the pc forward.
  assign advance   = (state == S_WAIT) && imem_rvalid && !kill && !redirect_valid;
  assign hold      = (state == S_HOLD) && !if_ready;
  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;

  fetch_pc_sel #(.ADDR_W(ADDR_W)) u_pc_sel (
    .pc       (pc),
    .redirect (redirect_valid),
    .target   (redirect_target),
    .advance  (advance),
    .hold     (hold),
    .next_pc  (pc_next),
    .misalign (misalign_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      pc       <= ADDR_W'(RESET_PC);
      req_pc   <= ADDR_W'(RESET_PC);
      kill     <= 1'b0;
      if_valid <= 1'b0;
      if_pc    <= ADDR_W'(RESET_PC);
      if_instr <= 32'h0;
      misalign <= 1'b0;
    end else begin
      pc       <= pc_next;
      misalign <= misalign_next;
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (imem_gnt) begin
            req_pc <= pc;
            kill   <= redirect_valid;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            kill <= 1'b0;
            if (kill || redirect_valid) begin
              state <= S_FETCH;
            end else begin
              if_instr <= imem_rdata;
              if_pc    <= req_pc;
              if_valid <= 1'b1;
              state    <= S_HOLD;
            end
          end else if (redirect_valid) begin
            kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_valid || if_ready) begin
            if_valid <= 1'b0;
            state    <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed and randomized checks of fetch_ctrl against a program-order model
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        misalign;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h0000_3000), .ADDR_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .if_ready        (if_ready),
    .misalign        (misalign)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  int          n_tx  = 0;
  int          cyc   = 0;
  logic [31:0] exp_next;
  logic        exp_mis;
  bit          pend = 1'b0;
  logic [31:0] pend_addr;
  int          pend_cnt = 0;
  int          mem_lat = 1;
  bit          rand_lat = 1'b0;
  bit          spur = 1'b0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory returns word_of(addr) after a latency; the model tracks the next pc decode must see.
  task automatic tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hBAD0_0000 ^ 32'(cyc);
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_of(pend_addr);
        pend        = 1'b0;
      end
    end else if (spur) begin
      imem_rvalid = 1'b1;
    end
    #1;
    chk("misalign", 32'(misalign), 32'(exp_mis));
    if (imem_req === 1'b1 && imem_gnt) begin
      chk("imem_addr", imem_addr, exp_next);
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_cnt  = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
    end
    if (if_valid === 1'b1 && if_ready) begin
      chk("if_pc", if_pc, exp_next);
      chk("if_instr", if_instr, word_of(exp_next));
      exp_next = exp_next + 32'd4;
      n_tx++;
    end
    exp_mis = redirect_valid && (redirect_target[1:0] != 2'b00);
    if (redirect_valid) exp_next = {redirect_target[31:2], 2'b00};
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'h0000_3000);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_mis", 32'(misalign), 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_3000);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    exp_next = 32'h0000_3000;
    exp_mis  = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (if_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(if_valid), 32'd1);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(imem_req), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_target = 32'h0; if_ready = 1'b0;
    exp_next = 32'h0000_3000; exp_mis = 1'b0;
    #2;
    do_reset();

    // Zero-wait memory: one instruction every third cycle.
    imem_gnt = 1'b1; if_ready = 1'b1; mem_lat = 1;
    chk("idle_req", 32'(imem_req), 32'd0);
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      chk("zw_valid", 32'(if_valid), 32'd1);
      chk("zw_pc", if_pc, 32'h0000_3000 + 32'(4 * k));
      tick();
      chk("zw_gap", 32'(if_valid), 32'd0);
      tick();
      tick();
    end

    // Backpressure in HOLD.
    if_ready = 1'b0;
    repeat (5) begin
      chk("hold_valid", 32'(if_valid), 32'd1);
      chk("hold_pc", if_pc, 32'h0000_300C);
      chk("hold_instr", if_instr, word_of(32'h0000_300C));
      chk("hold_req", 32'(imem_req), 32'd0);
      chk("hold_addr", imem_addr, 32'h0000_3010);
      tick();
    end
    if_ready = 1'b1;
    tick();
    chk("resume_req", 32'(imem_req), 32'd1);
    chk("resume_addr", imem_addr, 32'h0000_3010);

    // Redirect while waiting on a slow response.
    mem_lat = 3;
    tick();
    redirect_valid = 1'b1; redirect_target = 32'h0000_4000;
    tick();
    redirect_valid = 1'b0;
    repeat (2) begin
      chk("kill_valid", 32'(if_valid), 32'd0);
      tick();
    end
    chk("redir_req", 32'(imem_req), 32'd1);
    chk("redir_addr", imem_addr, 32'h0000_4000);

    // Redirect in the same cycle as the grant.
    mem_lat = 1;
    redirect_valid = 1'b1; redirect_target = 32'h0000_5000;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("gnt_redir_req", 32'(imem_req), 32'd1);
    chk("gnt_redir_addr", imem_addr, 32'h0000_5000);
    tick();
    tick();
    chk("gnt_redir_valid", 32'(if_valid), 32'd1);
    chk("gnt_redir_pc", if_pc, 32'h0000_5000);

    // Misaligned redirect from HOLD.
    redirect_valid = 1'b1; redirect_target = 32'h0000_6002;
    tick();
    redirect_valid = 1'b0; imem_gnt = 1'b0;
    chk("mis_pulse", 32'(misalign), 32'd1);
    chk("mis_addr", imem_addr, 32'h0000_6000);
    tick();
    chk("mis_clear", 32'(misalign), 32'd0);

    // PC wrap at the top of the address space.
    imem_gnt = 1'b1;
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    wait_valid("wrap_wait");
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    tick();
    wait_req("wrap_req");
    chk("wrap_addr", imem_addr, 32'h0000_0000);

    // Reset mid-WAIT; the late response lands after release and must be ignored.
    mem_lat = 3;
    tick();
    tick();
    do_reset();
    wait_req("post_rst_req");
    chk("post_rst_addr", imem_addr, 32'h0000_3000);
    wait_valid("post_rst_wait");
    chk("post_rst_pc", if_pc, 32'h0000_3000);
    chk("post_rst_instr", if_instr, word_of(32'h0000_3000));

    // Randomized traffic against the program-order model.
    rand_lat = 1'b1;
    repeat (3000) begin
      imem_gnt        = ($urandom % 4) != 0;
      if_ready        = ($urandom % 3) != 0;
      redirect_valid  = ($urandom % 12) == 0;
      redirect_target = $urandom;
      if (($urandom % 6) == 0) redirect_target = 32'hFFFF_FFF0 | 32'($urandom % 16);
      spur            = ($urandom % 5) == 0;
      tick();
    end
    chk("progress", 32'(n_tx > 100), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
